// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer. It fetches one instruction per FETCH/EXEC pair,
// supports absolute jumps and relative branches, and stops in a terminal HALT
// state on request or when instruction memory fails to acknowledge a fetch.
//
// Parameters
//   RESET_VEC     PC value loaded on reset
//   PC_STEP       sequential PC increment
//   TIMEOUT       FETCH cycles without ack before a fault halt (1..255)
//
// Ports
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset
//   imem_req      fetch request (FETCH only)
//   imem_addr     fetch address, always equal to pc
//   imem_ack      instruction memory returned data for imem_addr
//   instr_valid   instruction is executing this cycle (EXEC only)
//   stall         hold the current instruction in EXEC
//   jump          absolute redirect to jump_target
//   jump_target   absolute next PC
//   branch_taken  relative redirect by branch_off
//   branch_off    two's-complement offset in PC units
//   halt          stop sequencing
//   pc            current program counter
//   halted        sequencer is in HALT
//   fault         HALT was entered by fetch timeout (sticky until reset)
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [7:0]  RESET_VEC = 8'h00,
    parameter logic [7:0]  PC_STEP   = 8'd1,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    output logic       instr_valid,
    input  logic       stall,
    input  logic       jump,
    input  logic [7:0] jump_target,
    input  logic       branch_taken,
    input  logic [7:0] branch_off,
    input  logic       halt,
    output logic [7:0] pc,
    output logic       halted,
    output logic       fault
);

    localparam int unsigned PC_W   = 8;
    localparam int unsigned WAIT_W = 8;

    // Last wait-count value tolerated before the fetch is declared dead.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;
    logic              imem_req_q, imem_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic              halted_q, halted_d;

    logic [PC_W-1:0]   pc_seq_c;
    logic [PC_W-1:0]   pc_branch_c;

    // Candidate next PCs; 8-bit arithmetic wraps naturally modulo 256.
    assign pc_seq_c    = PC_W'(pc_q + PC_STEP);
    assign pc_branch_c = PC_W'(pc_seq_c + branch_off);

    // Next-state, PC and wait-counter logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wait_d  = wait_q;
        fault_d = fault_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end

            S_FETCH: begin
                // An ack in the timeout cycle still wins.
                if (imem_ack) begin
                    state_d = S_EXEC;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = WAIT_W'(wait_q + 1'b1);
                end
            end

            S_EXEC: begin
                // Priority: halt > stall > jump > branch > sequential.
                if (halt) begin
                    state_d = S_HALT;
                end else if (stall) begin
                    state_d = S_EXEC;
                end else if (jump) begin
                    pc_d    = jump_target;
                    state_d = S_FETCH;
                    wait_d  = '0;
                end else if (branch_taken) begin
                    pc_d    = pc_branch_c;
                    state_d = S_FETCH;
                    wait_d  = '0;
                end else begin
                    pc_d    = pc_seq_c;
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs are decoded from the next state and registered alongside it.
    always_comb begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        halted_d      = 1'b0;
        unique case (state_d)
            S_FETCH: imem_req_d    = 1'b1;
            S_EXEC:  instr_valid_d = 1'b1;
            S_HALT:  halted_d      = 1'b1;
            default: ;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VEC;
            wait_q        <= '0;
            fault_q       <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            wait_q        <= wait_d;
            fault_q       <= fault_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer with RESET_VEC=8'h80, PC_STEP=1,
// TIMEOUT=15. Expected fetch addresses go into a scoreboard queue when the
// EXEC decision is driven and are popped when the next FETCH is observed.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [7:0]  RV = 8'h80;
    localparam int unsigned TO = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic       instr_valid;
    logic       stall;
    logic       jump;
    logic [7:0] jump_target;
    logic       branch_taken;
    logic [7:0] branch_off;
    logic       halt;
    logic [7:0] pc;
    logic       halted;
    logic       fault;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_pc;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_VEC (RV),
        .PC_STEP   (8'd1),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .halt         (halt),
        .pc           (pc),
        .halted       (halted),
        .fault        (fault)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        imem_ack     = 1'b0;
        stall        = 1'b0;
        jump         = 1'b0;
        jump_target  = 8'h00;
        branch_taken = 1'b0;
        branch_off   = 8'h00;
        halt         = 1'b0;
    endtask

    // From FETCH: ack, jump to target, ack again; ends in EXEC at target.
    task automatic goto_exec(input logic [7:0] target);
        imem_ack = 1'b1;
        tick();
        imem_ack    = 1'b0;
        jump        = 1'b1;
        jump_target = target;
        tick();
        jump     = 1'b0;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
        n_checks++; if (pc !== RV) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RV); end
        n_checks++; if (imem_addr !== RV) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RV); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_first_fetch: got %b want 1", imem_req); end
    endtask

    // 130 instructions from 8'h80 cover the FF -> 00 wrap.
    task automatic test_sequential;
        exp_q.push_back(RV);
        for (int i = 0; i < 130; i++) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL seq_fetch: scoreboard empty at step %0d", i);
                exp_pc = 8'h00;
            end else begin
                exp_pc = exp_q.pop_front();
                if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
                    n_fail++; $display("FAIL seq_fetch: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp_pc);
                end
            end
            imem_ack = 1'b1;
            tick();
            imem_ack = 1'b0;
            n_checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== exp_pc) begin
                n_fail++; $display("FAIL seq_exec: valid=%b req=%b pc=%h want valid=1 req=0 pc=%h", instr_valid, imem_req, pc, exp_pc);
            end
            exp_q.push_back(8'(exp_pc + 8'd1));
            tick();
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL seq_final: scoreboard empty");
        end else begin
            exp_pc = exp_q.pop_front();
            if (imem_req !== 1'b1 || pc !== exp_pc || exp_pc !== 8'h02) begin
                n_fail++; $display("FAIL seq_final: req=%b pc=%h want req=1 pc=%h", imem_req, pc, exp_pc);
            end
        end
    endtask

    task automatic test_branch;
        goto_exec(8'h05);
        n_checks++; if (pc !== 8'h05 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL br_setup: pc=%h valid=%b want pc=05 valid=1", pc, instr_valid); end
        branch_taken = 1'b1;
        branch_off   = 8'hFD;
        exp_q.push_back(8'h03);
        tick();
        clear_inputs();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL br_back: scoreboard empty");
        end else begin
            exp_pc = exp_q.pop_front();
            if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin n_fail++; $display("FAIL br_back: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp_pc); end
        end
        goto_exec(8'h10);
        n_checks++; if (pc !== 8'h10) begin n_fail++; $display("FAIL jmp_setup: pc=%h want 10", pc); end
        jump         = 1'b1;
        jump_target  = 8'h40;
        branch_taken = 1'b1;
        branch_off   = 8'h07;
        exp_q.push_back(8'h40);
        tick();
        clear_inputs();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL jmp_prio: scoreboard empty");
        end else begin
            exp_pc = exp_q.pop_front();
            if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin n_fail++; $display("FAIL jmp_prio: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp_pc); end
        end
    endtask

    task automatic test_stall;
        goto_exec(8'h07);
        n_checks++; if (instr_valid !== 1'b1 || pc !== 8'h07) begin n_fail++; $display("FAIL stall_c1: valid=%b pc=%h want 1 07", instr_valid, pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (instr_valid !== 1'b1 || pc !== 8'h07 || imem_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d: valid=%b pc=%h req=%b want 1 07 0", i, instr_valid, pc, imem_req);
            end
        end
        stall = 1'b0;
        exp_q.push_back(8'h08);
        tick();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL stall_release: scoreboard empty");
        end else begin
            exp_pc = exp_q.pop_front();
            if (instr_valid !== 1'b0 || imem_req !== 1'b1 || pc !== exp_pc) begin
                n_fail++; $display("FAIL stall_release: valid=%b req=%b pc=%h want 0 1 %h", instr_valid, imem_req, pc, exp_pc);
            end
        end
        // EXEC controls must be ignored while fetching.
        jump         = 1'b1;
        jump_target  = 8'hAA;
        branch_taken = 1'b1;
        branch_off   = 8'h10;
        halt         = 1'b1;
        tick();
        clear_inputs();
        n_checks++;
        if (imem_req !== 1'b1 || pc !== 8'h08 || halted !== 1'b0) begin
            n_fail++; $display("FAIL fetch_ignore: req=%b pc=%h halted=%b want 1 08 0", imem_req, pc, halted);
        end
        stall    = 1'b1;
        imem_ack = 1'b1;
        tick();
        clear_inputs();
        n_checks++; if (instr_valid !== 1'b1 || pc !== 8'h08) begin n_fail++; $display("FAIL fetch_stall_ignore: valid=%b pc=%h want 1 08", instr_valid, pc); end
        exp_q.push_back(8'h09);
        tick();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL stall_next: scoreboard empty");
        end else begin
            exp_pc = exp_q.pop_front();
            if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin n_fail++; $display("FAIL stall_next: req=%b addr=%h want 1 %h", imem_req, imem_addr, exp_pc); end
        end
    endtask

    task automatic test_timeout;
        int n;
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        n_checks++; if (n != int'(TO)) begin n_fail++; $display("FAIL to_req_cycles: got %0d want %0d", n, TO); end
        n_checks++;
        if (halted !== 1'b1 || fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL to_halt: halted=%b fault=%b req=%b valid=%b want 1 1 0 0", halted, fault, imem_req, instr_valid);
        end
        imem_ack    = 1'b1;
        jump        = 1'b1;
        jump_target = 8'h55;
        repeat (3) tick();
        clear_inputs();
        n_checks++;
        if (halted !== 1'b1 || pc !== 8'h09 || imem_req !== 1'b0 || fault !== 1'b1) begin
            n_fail++; $display("FAIL to_terminal: halted=%b pc=%h req=%b fault=%b want 1 09 0 1", halted, pc, imem_req, fault);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (fault !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL to_reset_clear: fault=%b halted=%b want 0 0", fault, halted); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || pc !== RV) begin n_fail++; $display("FAIL to_refetch: req=%b pc=%h want 1 %h", imem_req, pc, RV); end
        repeat (TO - 1) tick();
        n_checks++; if (imem_req !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL to_last_cycle: req=%b halted=%b want 1 0", imem_req, halted); end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || fault !== 1'b0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL to_late_ack: valid=%b fault=%b halted=%b want 1 0 0", instr_valid, fault, halted);
        end
        exp_q.push_back(8'(RV + 8'd1));
        tick();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL to_resume: scoreboard empty");
        end else begin
            exp_pc = exp_q.pop_front();
            if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin n_fail++; $display("FAIL to_resume: req=%b addr=%h want 1 %h", imem_req, imem_addr, exp_pc); end
        end
    endtask

    task automatic test_halt;
        goto_exec(8'h22);
        n_checks++; if (pc !== 8'h22 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL halt_setup: pc=%h valid=%b want 22 1", pc, instr_valid); end
        halt  = 1'b1;
        stall = 1'b1;
        tick();
        clear_inputs();
        n_checks++;
        if (halted !== 1'b1 || pc !== 8'h22 || fault !== 1'b0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL halt_prio: halted=%b pc=%h fault=%b valid=%b req=%b want 1 22 0 0 0", halted, pc, fault, instr_valid, imem_req);
        end
        imem_ack     = 1'b1;
        jump         = 1'b1;
        jump_target  = 8'h55;
        branch_taken = 1'b1;
        branch_off   = 8'h01;
        repeat (3) tick();
        clear_inputs();
        n_checks++;
        if (halted !== 1'b1 || pc !== 8'h22 || imem_req !== 1'b0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL halt_terminal: halted=%b pc=%h req=%b fault=%b want 1 22 0 0", halted, pc, imem_req, fault);
        end
    endtask

    task automatic test_reset_mid_fetch;
        int n;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b1;
        tick();
        imem_ack    = 1'b0;
        jump        = 1'b1;
        jump_target = 8'h33;
        tick();
        clear_inputs();
        tick();
        n_checks++; if (imem_req !== 1'b1 || pc !== 8'h33) begin n_fail++; $display("FAIL mid_setup: req=%b pc=%h want 1 33", imem_req, pc); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (pc !== RV || imem_addr !== RV || imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: pc=%h addr=%h req=%b valid=%b halted=%b fault=%b want %h %h 0 0 0 0", pc, imem_addr, imem_req, instr_valid, halted, fault, RV, RV);
        end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RV) begin n_fail++; $display("FAIL mid_refetch: req=%b addr=%h want 1 %h", imem_req, imem_addr, RV); end
        // Wait counter must restart from zero after the reset.
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        n_checks++; if (n != int'(TO) || fault !== 1'b1) begin n_fail++; $display("FAIL mid_wait_clear: cycles=%0d fault=%b want %0d 1", n, fault, TO); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_timeout();
        test_halt();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VEC, default 8'h00: PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 8'd1: sequential PC increment.
REQ-003 SHALL have parameter TIMEOUT, default 15, range 1..255: number of FETCH cycles without ack before fault.
REQ-004 SHALL have port clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1: synchronous, active-low reset.
REQ-006 SHALL have port imem_req  out  1: instruction fetch request.
REQ-007 SHALL have port imem_addr  out  8: fetch address, always equal to pc.
REQ-008 SHALL have port imem_ack  in  1: instruction memory has returned data for imem_addr.
REQ-009 SHALL have port instr_valid  out  1: fetched instruction is being executed this cycle.
REQ-010 SHALL have port stall  in  1: hold the current instruction in EXEC.
REQ-011 SHALL have port jump  in  1: absolute redirect request.
REQ-012 SHALL have port jump_target  in  8: absolute next PC.
REQ-013 SHALL have port branch_taken  in  1: relative redirect request.
REQ-014 SHALL have port branch_off  in  8: two's-complement offset, in PC units.
REQ-015 SHALL have port halt  in  1: stop sequencing.
REQ-016 SHALL have port pc  out  8: current program counter (registered).
REQ-017 SHALL have port halted  out  1: sequencer is in HALT.
REQ-018 SHALL have port fault  out  1: HALT was entered by fetch timeout (sticky).

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, EXEC and HALT.
REQ-020 SHALL drive Moore outputs: imem_req=1 only in FETCH; instr_valid=1 only in EXEC; halted=1 only in HALT.
REQ-021 SHALL go from IDLE to FETCH unconditionally after one cycle.
REQ-022 SHALL keep a wait counter cleared on FETCH entry and incremented each FETCH cycle with imem_ack=0.
REQ-023 SHALL, in FETCH with imem_ack=1, go to EXEC; pc is unchanged.
REQ-024 SHALL, in FETCH with imem_ack=0 and wait counter = TIMEOUT-1, go to HALT and set fault=1; imem_ack=1 in that same cycle wins and goes to EXEC.
REQ-025 SHALL evaluate EXEC inputs in priority order: halt > stall > jump > branch_taken > sequential.
REQ-026 SHALL, on halt in EXEC, go to HALT with pc held and fault unchanged.
REQ-027 SHALL, on stall in EXEC, stay in EXEC with pc held and instr_valid held at 1.
REQ-028 SHALL, on jump in EXEC, set pc <= jump_target and go to FETCH.
REQ-029 SHALL, on branch_taken in EXEC, set pc <= pc + PC_STEP + branch_off, modulo 256, sign-extension irrelevant at 8 bits, and go to FETCH.
REQ-030 SHALL otherwise, in EXEC, set pc <= pc + PC_STEP modulo 256 (8'hFF+1 -> 8'h00) and go to FETCH.
REQ-031 SHALL keep HALT terminal until reset: pc held, imem_req=0; all EXEC inputs and imem_ack are ignored.
REQ-032 SHALL ignore jump, branch_taken, stall and halt outside EXEC.

Reset
REQ-033 SHALL, when rst_n=0 at a rising clk edge in any state including mid-FETCH, set state=IDLE, pc=RESET_VEC, wait counter=0 and fault=0.
REQ-034 SHALL, during and on the cycle after reset, hold imem_req=0, instr_valid=0 and halted=0, with imem_addr=RESET_VEC.

Verification
REQ-035 SHALL pass this test: reset, then imem_ack=1 whenever imem_req=1 -> pc sequence 00,01,02,... with one FETCH and one EXEC cycle per instruction; pc 8'hFF wraps to 8'h00.
REQ-036 SHALL pass this test: EXEC at pc=05 with branch_taken=1 and branch_off=8'hFD -> next pc=03; at pc=10 with jump=1, jump_target=8'h40 and branch_taken=1 -> pc=40.
REQ-037 SHALL pass this test: stall=1 for 3 cycles in EXEC at pc=07 -> instr_valid high for 4 consecutive cycles, pc=07 throughout, then pc=08.
REQ-038 SHALL pass this test: imem_ack held 0 with TIMEOUT=15 -> imem_req high for exactly 15 cycles, then halted=1, fault=1 and imem_req=0; ack arriving on the 15th cycle gives EXEC with fault=0.
REQ-039 SHALL pass this test: halt=1 together with stall=1 in EXEC at pc=22 -> HALT with pc=22 and fault=0; a later imem_ack or jump causes no change.
REQ-040 SHALL pass this test: rst_n=0 for one cycle during FETCH at pc=33 with RESET_VEC=8'h80 -> next cycle pc=80, IDLE with all outputs 0, then FETCH at 80.
